// File: rtl/temp_bcd_pkg.sv
// Shared types and constants for the XADC-to-BCD temperature converter.
//   state_e    : converter FSM states
//   BLANK_CODE : nibble value the 7-segment multiplexer renders as an unlit digit
//   nines_const: BCD all-nines pattern for a given digit count (right-aligned, 16 bits)
package temp_bcd_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCapture = 3'd1,
    StDivide  = 3'd2,
    StOutput  = 3'd3,
    StHold    = 3'd4
  } state_e;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int unsigned MAX_DIGITS = 4;

  function automatic logic [4*MAX_DIGITS-1:0] nines_const(input int unsigned digits);
    logic [4*MAX_DIGITS-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) r[4*i +: 4] = 4'h9;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// DIGITS-digit synchronous BCD incrementer.
//   CLK, RST  : clock, synchronous active-high reset (count -> 0)
//   clr       : load zero (wins over inc)
//   inc       : ripple-increment by one; each nibble stays in 0..9
//   count     : current BCD value
//   all_nines : count is 9..9
//   last_inc  : count is 9..98, i.e. the next increment reaches all nines
module bcd_counter
  import temp_bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                clr,
  input  logic                inc,
  output logic [4*DIGITS-1:0] count,
  output logic                all_nines,
  output logic                last_inc
);

  localparam logic [4*MAX_DIGITS-1:0] NinesFull = nines_const(DIGITS);
  localparam logic [4*DIGITS-1:0]     Nines     = NinesFull[4*DIGITS-1:0];
  // Units digit 9 -> 8 never borrows, so a binary decrement gives the BCD value.
  localparam logic [4*DIGITS-1:0]     NinesM1   = Nines - 1'b1;

  logic [4*DIGITS-1:0] count_q, count_d;

  always_comb begin
    logic carry;
    count_d = count_q;
    carry   = inc;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_d[4*i +: 4] = 4'd0;
        end else begin
          count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    if (clr) count_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count     = count_q;
  assign all_nines = (count_q == Nines);
  assign last_inc  = (count_q == NinesM1);

endmodule

// File: rtl/temp_bcd_converter.sv
// XADC code to BCD temperature converter: bcd = min(din / SCALE, 10**DIGITS-1),
// computed by repeated subtraction at one step per clock.
//   CLK, RST : clock, synchronous active-high reset
//   en       : conversion request level; dropping it aborts and blanks the display
//   din      : raw XADC code, sampled once per conversion in CAPTURE
//   bcd      : result digits, 4'hF = blank
//   busy     : conversion in progress
//   done     : one-cycle pulse when bcd updates
//   ovf      : last result saturated at all nines
//   display  : combinational copy of en
module temp_bcd_converter
  import temp_bcd_pkg::*;
#(
  parameter int unsigned IN_W     = 12,
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned SCALE    = 68,
  parameter int unsigned BLANK_LZ = 0,
  parameter int unsigned REFRESH  = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                en,
  input  logic [IN_W-1:0]     din,
  output logic [4*DIGITS-1:0] bcd,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic                display
);

  localparam logic [IN_W-1:0]     ScaleW   = IN_W'(SCALE);
  localparam logic [4*DIGITS-1:0] AllBlank = {DIGITS{BLANK_CODE}};
  localparam int unsigned         TimerW   = (REFRESH > 0) ? $clog2(REFRESH + 1) : 1;
  localparam logic [TimerW-1:0]   TimerEnd = TimerW'(REFRESH);

  state_e              state_q, state_d;
  logic [IN_W-1:0]     cap_q, cap_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                sat_q, sat_d;     // saturation flag of the conversion in flight
  logic [TimerW-1:0]   timer_q, timer_d;

  logic                cnt_clr, cnt_inc;
  logic [4*DIGITS-1:0] count;
  logic                all_nines, last_inc;
  logic [IN_W-1:0]     cap_minus;
  logic [4*DIGITS-1:0] count_blanked;

  bcd_counter #(
    .DIGITS (DIGITS)
  ) u_cnt (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .count     (count),
    .all_nines (all_nines),
    .last_inc  (last_inc)
  );

  assign cap_minus = cap_q - ScaleW;

  // Leading-zero blanking from the MS digit down; the units digit is always shown.
  always_comb begin
    logic lead;
    count_blanked = count;
    lead          = 1'b1;
    if (BLANK_LZ != 0) begin
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
        if (lead && (count[4*i +: 4] == 4'd0)) count_blanked[4*i +: 4] = BLANK_CODE;
        else                                   lead = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    sat_d   = sat_q;
    timer_d = timer_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;

    case (state_q)
      StIdle: begin
        bcd_d  = AllBlank;
        busy_d = 1'b0;
        if (en) state_d = StCapture;
      end

      StCapture: begin
        if (!en) begin
          state_d = StIdle;
          bcd_d   = AllBlank;
          busy_d  = 1'b0;
        end else begin
          cap_d   = din;
          cnt_clr = 1'b1;
          busy_d  = 1'b1;
          sat_d   = 1'b0;
          // Decide on the live input; cap_q still holds the previous sample.
          state_d = (din >= ScaleW) ? StDivide : StOutput;
        end
      end

      StDivide: begin
        if (!en) begin
          state_d = StIdle;
          bcd_d   = AllBlank;
          busy_d  = 1'b0;
        end else if (all_nines && (cap_q >= ScaleW)) begin
          sat_d   = 1'b1;
          state_d = StOutput;
        end else begin
          cap_d   = cap_minus;
          cnt_inc = 1'b1;
          if (cap_minus < ScaleW) begin
            state_d = StOutput;
          end else if (last_inc) begin
            // This step reaches all nines with quotient still left over: stop
            // here so a saturated result keeps the same q+3 latency.
            sat_d   = 1'b1;
            state_d = StOutput;
          end
        end
      end

      StOutput: begin
        bcd_d   = count_blanked;
        ovf_d   = sat_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        timer_d = '0;
        state_d = StHold;
      end

      StHold: begin
        if (!en) begin
          state_d = StIdle;
          bcd_d   = AllBlank;
        end else if (REFRESH != 0) begin
          // Count REFRESH cycles after the done cycle, then spend one more cycle
          // here so a refresh restart has the same latency as a start from IDLE.
          if (timer_q == TimerEnd) begin
            timer_d = '0;
            state_d = StCapture;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
        cap_d   = '0;
        bcd_d   = AllBlank;
        busy_d  = 1'b0;
        ovf_d   = 1'b0;
        sat_d   = 1'b0;
        timer_d = '0;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cap_q   <= '0;
      bcd_q   <= AllBlank;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      sat_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      sat_q   <= sat_d;
      timer_q <= timer_d;
    end
  end

  assign bcd     = bcd_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ovf     = ovf_q;
  assign display = en;

endmodule
